// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALUOp/funct/CONF codes, FSM states and the instruction decoder
package alu_ctrl_pkg;
  localparam logic [3:0] AOP_ADDU = 4'h0, AOP_SLTU = 4'h1, AOP_AND = 4'h2,
                         AOP_RTYPE = 4'h3, AOP_ADD = 4'h4, AOP_SLT = 4'h5;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                         FN_MFHI = 6'h10, FN_MFLO = 6'h12,
                         FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1a, FN_DIVU = 6'h1b,
                         FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
                         FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  typedef enum logic [4:0] {
    CONF_ADD = 5'd0, CONF_SUB = 5'd1, CONF_AND = 5'd2, CONF_OR = 5'd3,
    CONF_XOR = 5'd4, CONF_NOR = 5'd5, CONF_SLL = 5'd6, CONF_SRL = 5'd7,
    CONF_SRA = 5'd8, CONF_SLT = 5'd9, CONF_MUL = 5'd10, CONF_DIV = 5'd11,
    CONF_MFHI = 5'd12, CONF_MFLO = 5'd13, CONF_ILLEGAL = 5'd31
  } conf_e;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_FIN} state_e;
  typedef struct packed {
    conf_e conf;
    logic  sign;
  } dec_t;

  function automatic dec_t decode_funct(logic [5:0] fn);
    dec_t d;
    case (fn)
      FN_ADD:   d = '{CONF_ADD, 1'b1};
      FN_ADDU:  d = '{CONF_ADD, 1'b0};
      FN_SUB:   d = '{CONF_SUB, 1'b1};
      FN_SUBU:  d = '{CONF_SUB, 1'b0};
      FN_AND:   d = '{CONF_AND, 1'b1};
      FN_OR:    d = '{CONF_OR, 1'b1};
      FN_XOR:   d = '{CONF_XOR, 1'b1};
      FN_NOR:   d = '{CONF_NOR, 1'b1};
      FN_SLL:   d = '{CONF_SLL, 1'b0};
      FN_SRL:   d = '{CONF_SRL, 1'b0};
      FN_SRA:   d = '{CONF_SRA, 1'b1};
      FN_SLT:   d = '{CONF_SLT, 1'b1};
      FN_SLTU:  d = '{CONF_SLT, 1'b0};
      FN_MULT:  d = '{CONF_MUL, 1'b1};
      FN_MULTU: d = '{CONF_MUL, 1'b0};
      FN_DIV:   d = '{CONF_DIV, 1'b1};
      FN_DIVU:  d = '{CONF_DIV, 1'b0};
      FN_MFHI:  d = '{CONF_MFHI, 1'b0};
      FN_MFLO:  d = '{CONF_MFLO, 1'b0};
      default:  d = '{CONF_ILLEGAL, 1'b0};
    endcase
    return d;
  endfunction

  function automatic dec_t decode(logic [3:0] op, logic [5:0] fn);
    dec_t d;
    case (op)
      AOP_ADDU:  d = '{CONF_ADD, 1'b0};
      AOP_SLTU:  d = '{CONF_SLT, 1'b0};
      AOP_AND:   d = '{CONF_AND, 1'b0};
      AOP_RTYPE: d = decode_funct(fn);
      AOP_ADD:   d = '{CONF_ADD, 1'b1};
      AOP_SLT:   d = '{CONF_SLT, 1'b1};
      default:   d = '{CONF_ILLEGAL, 1'b0};
    endcase
    return d;
  endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative magnitude shift-add multiplier / restoring divider with sign fix-up
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             div_op,
  input  logic             sign_op,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic             dz,
  output logic [WIDTH-1:0] hi_fix,
  output logic [WIDTH-1:0] lo_fix
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, p_next, prod;
  logic [WIDTH-1:0] mb, a_raw, ma, mbn, quo, rem;
  logic [WIDTH:0] add_sum, div_sh, div_diff;
  logic is_div, neg_q, neg_r;
  assign ma = sign_op && a[WIDTH-1] ? -a : a;
  assign mbn = sign_op && b[WIDTH-1] ? -b : b;
  // p holds {partial product, multiplier} for mult and {remainder, quotient} for div
  assign add_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mb} : '0);
  assign div_sh = p[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, mb};
  assign p_next = !is_div ? {add_sum, p[WIDTH-1:1]} :
                  div_diff[WIDTH] ? {div_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0} :
                  {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  assign prod = neg_q ? -p : p;
  assign quo = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rem = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  assign hi_fix = !is_div ? prod[2*WIDTH-1:WIDTH] : dz ? a_raw : rem;
  assign lo_fix = !is_div ? prod[WIDTH-1:0] : dz ? '1 : quo;
  assign last = cnt == CW'(WIDTH - 1);
  // latch magnitudes and sign-fix flags on load, then iterate one bit per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      p <= '0;
      mb <= '0;
      a_raw <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      p <= {{WIDTH{1'b0}}, ma};
      mb <= mbn;
      a_raw <= a;
      is_div <= div_op;
      neg_q <= sign_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sign_op && a[WIDTH-1];
      dz <= div_op && b == '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      p <= p_next;
    end
  end
endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: registered ALU-control decoder and ALU with iterative mult/div and HI/LO
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CONF_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [CONF_W-1:0]  alu_conf,
  output logic               sign,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               div_zero
);
  state_e state, state_nx;
  dec_t dec;
  logic accept, is_mul, is_div, mdu_last, mdu_dz;
  logic [WIDTH-1:0] alu_res, hi_fix, lo_fix;
  assign dec = decode(alu_op, funct);
  assign is_mul = dec.conf == CONF_MUL;
  assign is_div = dec.conf == CONF_DIV;
  assign ready = state == S_IDLE || state == S_FIN;
  assign done = state == S_FIN;
  assign accept = start && ready;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk(clk),
    .reset(reset),
    .load(accept && (is_mul || is_div)),
    .div_op(is_div),
    .sign_op(dec.sign),
    .step(state == S_MUL || state == S_DIV),
    .a(op_a),
    .b(op_b),
    .last(mdu_last),
    .dz(mdu_dz),
    .hi_fix(hi_fix),
    .lo_fix(lo_fix)
  );

  // single-cycle ALU on the live operands, captured at the accept edge
  always_comb begin
    alu_res = '0;
    case (dec.conf)
      CONF_ADD:  alu_res = op_a + op_b;
      CONF_SUB:  alu_res = op_a - op_b;
      CONF_AND:  alu_res = op_a & op_b;
      CONF_OR:   alu_res = op_a | op_b;
      CONF_XOR:  alu_res = op_a ^ op_b;
      CONF_NOR:  alu_res = ~(op_a | op_b);
      CONF_SLL:  alu_res = op_b << shamt;
      CONF_SRL:  alu_res = op_b >> shamt;
      CONF_SRA:  alu_res = $signed(op_b) >>> shamt;
      CONF_SLT:  alu_res = WIDTH'(dec.sign ? $signed(op_a) < $signed(op_b) : op_a < op_b);
      CONF_MFHI: alu_res = hi;
      CONF_MFLO: alu_res = lo;
      default:   alu_res = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  end

  // next state: accepts only in IDLE/FIN, so FIN can chain straight into the next op
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_FIN: state_nx = !accept ? S_IDLE : is_mul ? S_MUL : is_div ? S_DIV : S_FIN;
      S_MUL, S_DIV:  state_nx = mdu_last ? S_FIX : state;
      S_FIX:         state_nx = S_FIN;
      default:       state_nx = S_IDLE;
    endcase
  end

  // architectural outputs: decode/result at accept, HI/LO/result at the end of FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
      hi <= '0;
      lo <= '0;
      alu_conf <= '0;
      sign <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      alu_conf <= CONF_W'(dec.conf);
      sign <= dec.sign;
      div_zero <= 1'b0;
      if (!is_mul && !is_div) result <= alu_res;
    end else if (state == S_FIX) begin
      hi <= hi_fix;
      lo <= lo_fix;
      result <= lo_fix;
      div_zero <= mdu_dz;
    end
  end
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: directed and randomized checks of alu_ctrl_mdu against an arithmetic model
module tb_alu_ctrl_mdu;
  logic clk = 0, reset = 1, start = 0;
  logic [3:0] alu_op = 0;
  logic [5:0] funct = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic [4:0] shamt = 0;
  logic ready, done, sign, div_zero;
  logic [31:0] result, hi, lo;
  logic [4:0] alu_conf;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m_hi = 0, m_lo = 0, e_res;
  int e_conf, e_lat, lat;
  bit e_sign, e_dz;

  alu_ctrl_mdu dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .funct(funct),
    .op_a(op_a), .op_b(op_b), .shamt(shamt), .ready(ready), .done(done),
    .result(result), .alu_conf(alu_conf), .sign(sign), .hi(hi), .lo(lo),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // decode table as conf*2+sign
  function automatic int cs_of(logic [3:0] op, logic [5:0] fn);
    int r = 62;
    case (op)
      0: r = 0;
      1: r = 18;
      2: r = 4;
      4: r = 1;
      5: r = 19;
      3: case (fn)
           'h20: r = 1;   'h21: r = 0;   'h22: r = 3;   'h23: r = 2;
           'h24: r = 5;   'h25: r = 7;   'h26: r = 9;   'h27: r = 11;
           'h00: r = 12;  'h02: r = 14;  'h03: r = 17;  'h2a: r = 19;
           'h2b: r = 18;  'h18: r = 21;  'h19: r = 20;  'h1a: r = 23;
           'h1b: r = 22;  'h10: r = 24;  'h12: r = 26;
           default: r = 62;
         endcase
      default: r = 62;
    endcase
    return r;
  endfunction

  task automatic model(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    int cs;
    longint sa, sb;
    logic [63:0] p;
    cs = cs_of(op, fn);
    e_conf = cs >> 1;
    e_sign = cs[0];
    e_lat = 1;
    e_dz = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (e_conf)
      0: e_res = a + b;
      1: e_res = a - b;
      2: e_res = a & b;
      3: e_res = a | b;
      4: e_res = a ^ b;
      5: e_res = ~(a | b);
      6: e_res = b << sh;
      7: e_res = b >> sh;
      8: e_res = 32'(sb >> sh);
      9: e_res = e_sign ? 32'(sa < sb) : 32'(a < b);
      10: begin
        p = e_sign ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = p;
        e_res = m_lo;
        e_lat = 34;
      end
      11: begin
        if (b == 0) begin
          m_hi = a;
          m_lo = '1;
          e_dz = 1;
        end else if (e_sign) begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        e_res = m_lo;
        e_lat = 34;
      end
      12: e_res = m_hi;
      13: e_res = m_lo;
      default: e_res = 0;
    endcase
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    alu_op = op;
    funct = fn;
    op_a = a;
    op_b = b;
    shamt = sh;
  endtask

  task automatic wait_done(output int l);
    l = 1;
    while (!done && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, " done"}, done, 1);
    chk({tag, " latency"}, lat, e_lat);
    chk({tag, " result"}, result, e_res);
    chk({tag, " conf"}, alu_conf, e_conf);
    chk({tag, " sign"}, sign, e_sign);
    chk({tag, " hi"}, hi, m_hi);
    chk({tag, " lo"}, lo, m_lo);
    chk({tag, " div_zero"}, div_zero, e_dz);
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    chk({tag, " ready"}, ready, 1);
    drive(op, fn, a, b, sh);
    model(op, fn, a, b, sh);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    wait_done(lat);
    check_out(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " done"}, done, 0);
    chk({tag, " result"}, result, 0);
    chk({tag, " hi"}, hi, 0);
    chk({tag, " lo"}, lo, 0);
    chk({tag, " conf"}, alu_conf, 0);
    chk({tag, " sign"}, sign, 0);
    chk({tag, " div_zero"}, div_zero, 0);
  endtask

  logic [5:0] fns [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02,
                          6'h03, 6'h2a, 6'h2b, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12};

  initial begin
    int dcount, dlat;
    logic [31:0] dres;
    #2 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset ready", ready, 1);
    reset = 1;
    @(posedge clk);
    #1;
    issue("subu", 4'h3, 6'h23, 32'd5, 32'd7, 5'd0);
    chk("subu const", result, 32'hFFFFFFFE);
    // mult followed by mflo with start held through FIN
    drive(4'h3, 6'h18, 32'hFFFFFFFD, 32'd7, 5'd0);
    model(4'h3, 6'h18, 32'hFFFFFFFD, 32'd7, 5'd0);
    start = 1;
    @(posedge clk);
    #1;
    drive(4'h3, 6'h12, 32'h0, 32'h0, 5'd0);
    wait_done(lat);
    check_out("mult");
    chk("mult hi const", hi, 32'hFFFFFFFF);
    chk("mult lo const", lo, 32'hFFFFFFEB);
    model(4'h3, 6'h12, 32'h0, 32'h0, 5'd0);
    @(posedge clk);
    #1;
    start = 0;
    chk("b2b done", done, 1);
    wait_done(lat);
    check_out("mflo");
    chk("mflo const", result, 32'hFFFFFFEB);
    issue("div", 4'h3, 6'h1a, -32'sd7, 32'd2, 5'd0);
    chk("div lo const", lo, 32'hFFFFFFFD);
    chk("div hi const", hi, 32'hFFFFFFFF);
    issue("divu0", 4'h3, 6'h1b, 32'd7, 32'd0, 5'd0);
    chk("divu0 dz", div_zero, 1);
    chk("divu0 hi const", hi, 32'd7);
    chk("divu0 lo const", lo, 32'hFFFFFFFF);
    issue("intmin", 4'h3, 6'h1a, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    issue("div0 signed", 4'h3, 6'h1a, 32'hFFFFFFF0, 32'd0, 5'd0);
    // start pulse during DIV is ignored
    drive(4'h3, 6'h1b, 32'd100, 32'd7, 5'd0);
    model(4'h3, 6'h1b, 32'd100, 32'd7, 5'd0);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    drive(4'h0, 6'h0, 32'd1, 32'd2, 5'd0);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    dcount = 0;
    dlat = 0;
    dres = 0;
    for (int i = 7; i < 48; i++) begin
      if (done) begin
        if (dcount == 0) begin
          dlat = i;
          dres = result;
        end
        dcount++;
      end
      @(posedge clk);
      #1;
    end
    chk("busy start pulses", dcount, 1);
    chk("busy start latency", dlat, 34);
    chk("busy start result", dres, e_res);
    issue("illegal", 4'hF, 6'h20, 32'd9, 32'd9, 5'd0);
    chk("illegal conf const", alu_conf, 31);
    issue("slti", 4'h5, 6'h0, 32'hFFFFFFFF, 32'd0, 5'd0);
    chk("slti const", result, 1);
    // reset in the middle of a mult
    issue("pre", 4'h3, 6'h19, 32'h12345678, 32'h9ABCDEF0, 5'd0);
    drive(4'h3, 6'h18, 32'd1234, 32'd5678, 5'd0);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (9) @(posedge clk);
    #3;
    reset = 0;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1;
    m_hi = 0;
    m_lo = 0;
    @(posedge clk);
    #1;
    chk("post reset ready", ready, 1);
    chk("post reset done", done, 0);
    repeat (150) begin
      logic [3:0] op;
      logic [5:0] fn;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 9));
      if (op > 5) op = (op == 9) ? 4'($urandom_range(6, 15)) : 4'h3;
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 18)];
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 9);
        2: b = '1;
        default: b = $urandom;
      endcase
      issue("rand", op, fn, a, b, 5'($urandom_range(0, 31)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
